// File: rtl/alu_op_encoder.sv
// alu_op_encoder
// Sequential inverse of the ALU-control decoder. It accepts a requested 4-bit
// alu_op from the control FSM and issues the 3-bit control code {A,B,C} that
// the decoder maps back to that alu_op. The code is held stable for
// HOLD_CYCLES cycles and then offered downstream with a valid/ready
// handshake. Requests the decoder cannot produce are rejected and counted.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   in_valid     upstream request valid
//   in_ready     block can accept a request (high only in IDLE)
//   in_alu_op    requested ALU operation
//   out_code     control code {A,B,C}, A = out_code[2]
//   out_valid    out_code has settled and may be consumed
//   out_ready    downstream has consumed out_code
//   illegal      one-cycle pulse after an unencodable request is accepted
//   illegal_cnt  saturating count of unencodable requests
module alu_op_encoder #(
   parameter int unsigned HOLD_CYCLES = 1,
   parameter int unsigned CNT_W       = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_alu_op,
   output logic [2:0]       out_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_VALID = 2'd2
   } state_t;

   // Counter preload; for HOLD_CYCLES=0 the value is unused because the
   // FSM jumps straight to VALID.
   localparam logic [3:0]       HOLD_INIT = 4'(HOLD_CYCLES) - 4'd1;
   localparam logic             SKIP_HOLD = (HOLD_CYCLES == 0);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t     state_r;
   logic [3:0] hold_cnt_r;
   logic [3:0] enc_s;       // {legal, code}
   logic       op_legal_s;
   logic [2:0] op_code_s;

   // Inverse of the decoder table: returns {legal, code}.
   function automatic logic [3:0] encode_op(input logic [3:0] op);
      logic [3:0] res;
      case (op)
         4'b0010: res = {1'b1, 3'b000};
         4'b0000: res = {1'b1, 3'b001};
         4'b1101: res = {1'b1, 3'b010};
         4'b1001: res = {1'b1, 3'b011};
         4'b0100: res = {1'b1, 3'b100};
         4'b0001: res = {1'b1, 3'b101};
         4'b0111: res = {1'b1, 3'b110};
         4'b1010: res = {1'b1, 3'b111};
         default: res = {1'b0, 3'b000};
      endcase
      return res;
   endfunction

   // Combinational encode of the requested op.
   always_comb begin
      enc_s      = encode_op(in_alu_op);
      op_legal_s = enc_s[3];
      op_code_s  = enc_s[2:0];
   end

   // in_ready depends only on state, so no path from in_valid/out_ready.
   assign in_ready = (state_r == ST_IDLE);

   // Control FSM with registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r     <= ST_IDLE;
         hold_cnt_r  <= 4'd0;
         out_code    <= 3'b000;
         out_valid   <= 1'b0;
         illegal     <= 1'b0;
         illegal_cnt <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               illegal <= 1'b0;
               if (in_valid) begin
                  if (op_legal_s) begin
                     out_code   <= op_code_s;
                     hold_cnt_r <= HOLD_INIT;
                     if (SKIP_HOLD) begin
                        state_r   <= ST_VALID;
                        out_valid <= 1'b1;
                     end else begin
                        state_r   <= ST_HOLD;
                     end
                  end else begin
                     // Rejected: code untouched, pulse and count.
                     illegal <= 1'b1;
                     if (illegal_cnt != CNT_MAX) begin
                        illegal_cnt <= illegal_cnt + CNT_ONE;
                     end
                  end
               end
            end
            ST_HOLD: begin
               illegal <= 1'b0;
               if (hold_cnt_r == 4'd0) begin
                  state_r   <= ST_VALID;
                  out_valid <= 1'b1;
               end else begin
                  hold_cnt_r <= hold_cnt_r - 4'd1;
               end
            end
            ST_VALID: begin
               illegal <= 1'b0;
               if (out_ready) begin
                  state_r   <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               out_valid <= 1'b0;
               illegal   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_encoder.sv
// Self-checking bench for alu_op_encoder. Three instances cover
// HOLD_CYCLES = 1 (CNT_W=8), HOLD_CYCLES = 0 (CNT_W=2) and HOLD_CYCLES = 4.
// Expected codes are derived from a reference decoder table and pushed to a
// scoreboard queue at request time, then popped on each output handshake.
module tb_alu_op_encoder;

   logic       clk;
   logic       resetn;
   logic       iv   [3];
   logic [3:0] opv  [3];
   logic       ordy [3];
   logic       ir   [3];
   logic [2:0] code [3];
   logic       ov   [3];
   logic       ill  [3];
   logic [7:0] cnt_h1;
   logic [1:0] cnt_h0;
   logic [7:0] cnt_h4;

   int n_cmp;
   int n_fail;
   logic [2:0] exp_q[$];
   logic [3:0] dec_tbl [8];

   // k=0: HOLD 1, k=1: HOLD 0 / CNT_W 2, k=2: HOLD 4
   alu_op_encoder #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
      .clk(clk), .resetn(resetn), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_alu_op(opv[0]), .out_code(code[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .illegal(ill[0]), .illegal_cnt(cnt_h1));
   alu_op_encoder #(.HOLD_CYCLES(0), .CNT_W(2)) u_h0 (
      .clk(clk), .resetn(resetn), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_alu_op(opv[1]), .out_code(code[1]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .illegal(ill[1]), .illegal_cnt(cnt_h0));
   alu_op_encoder #(.HOLD_CYCLES(4), .CNT_W(8)) u_h4 (
      .clk(clk), .resetn(resetn), .in_valid(iv[2]), .in_ready(ir[2]),
      .in_alu_op(opv[2]), .out_code(code[2]), .out_valid(ov[2]),
      .out_ready(ordy[2]), .illegal(ill[2]), .illegal_cnt(cnt_h4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decoder: code -> alu_op.
   function automatic logic [3:0] ref_decode(input logic [2:0] c);
      return dec_tbl[c];
   endfunction

   // Inverse found by searching the decoder table; returns {legal, code}.
   function automatic logic [3:0] ref_encode(input logic [3:0] o);
      for (int c = 0; c < 8; c++) begin
         if (dec_tbl[c] == o) return {1'b1, 3'(c)};
      end
      return 4'b0000;
   endfunction

   // Drive one request on instance k once it is ready; returns just after
   // the accepting edge.
   task automatic issue(input int k, input logic [3:0] o, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (ir[k] === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         iv[k]  = 1'b1;
         opv[k] = o;
         @(posedge clk);
         #1;
         iv[k] = 1'b0;
      end
   endtask

   // Count edges (the accepting edge is edge 1) until out_valid is seen.
   // Returns at the negedge where out_valid is first high.
   task automatic wait_valid(input int k, output int edges, output bit ok);
      edges = 1;
      ok    = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (ov[k] === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         edges++;
      end
   endtask

   task automatic test_reset;
      #3 resetn = 1'b0;
      #1;
      n_cmp++;
      if (code[0] !== 3'b000 || ov[0] !== 1'b0 || ir[0] !== 1'b1 ||
          cnt_h1 !== 8'd0 || ill[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: code=%b valid=%b ready=%b cnt=%0d ill=%b, want 000 0 1 0 0",
                  code[0], ov[0], ir[0], cnt_h1, ill[0]);
      end
      n_cmp++;
      if (ir[1] !== 1'b1 || ir[2] !== 1'b1 || cnt_h0 !== 2'd0 || cnt_h4 !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_others: ready=%b%b cnt0=%0d cnt4=%0d, want 11 0 0",
                  ir[1], ir[2], cnt_h0, cnt_h4);
      end
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_encoding_sweep;
      logic [3:0] ops [8];
      logic [3:0] e;
      logic [2:0] got;
      int edges;
      bit ok;
      ops = '{4'b0010, 4'b0000, 4'b1101, 4'b1001, 4'b0100, 4'b0001, 4'b0111, 4'b1010};
      ordy[0] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         issue(0, ops[i], ok);
         e = ref_encode(ops[i]);
         exp_q.push_back(e[2:0]);
         wait_valid(0, edges, ok);
         n_cmp++;
         if (!ok || edges != 2) begin
            n_fail++;
            $display("FAIL sweep_latency op=%b: ok=%0d edges=%0d, want 2", ops[i], ok, edges);
         end
         got = code[0];
         if (exp_q.size() > 0) begin
            e[2:0] = exp_q.pop_front();
            n_cmp++;
            if (got !== e[2:0]) begin
               n_fail++;
               $display("FAIL sweep_code op=%b: got %b want %b", ops[i], got, e[2:0]);
            end
         end
         n_cmp++;
         if (ref_decode(got) !== ops[i]) begin
            n_fail++;
            $display("FAIL sweep_roundtrip: decode(%b)=%b want %b", got, ref_decode(got), ops[i]);
         end
         @(negedge clk);
         n_cmp++;
         if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_release op=%b: valid=%b ready=%b want 0 1", ops[i], ov[0], ir[0]);
         end
      end
   endtask

   task automatic test_illegal;
      logic [3:0] bad [2];
      bit ok;
      bad = '{4'b1111, 4'b0011};
      for (int i = 0; i < 2; i++) begin
         issue(0, bad[i], ok);
         @(negedge clk);
         n_cmp++;
         if (!ok || ill[0] !== 1'b1 || ir[0] !== 1'b1 || code[0] !== 3'b111) begin
            n_fail++;
            $display("FAIL illegal_pulse op=%b: ok=%0d ill=%b ready=%b code=%b want 1 1 111",
                     bad[i], ok, ill[0], ir[0], code[0]);
         end
         @(negedge clk);
         n_cmp++;
         if (ill[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_width op=%b: ill=%b want 0", bad[i], ill[0]);
         end
      end
      n_cmp++;
      if (cnt_h1 !== 8'd2) begin
         n_fail++;
         $display("FAIL illegal_cnt: got %0d want 2", cnt_h1);
      end
   endtask

   task automatic test_backpressure;
      logic [3:0] e;
      int edges;
      int bad;
      bit ok;
      ordy[0] = 1'b0;
      issue(0, 4'b0111, ok);
      e = ref_encode(4'b0111);
      exp_q.push_back(e[2:0]);
      wait_valid(0, edges, ok);
      n_cmp++;
      if (!ok) begin
         n_fail++;
         $display("FAIL bp_timeout: out_valid never rose");
      end
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (ov[0] !== 1'b1 || code[0] !== 3'b110 || ir[0] !== 1'b0) bad++;
         @(negedge clk);
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d bad cycles, last valid=%b code=%b ready=%b want 1 110 0",
                  bad, ov[0], code[0], ir[0]);
      end
      ordy[0] = 1'b1;
      if (exp_q.size() > 0) begin
         e[2:0] = exp_q.pop_front();
         n_cmp++;
         if (code[0] !== e[2:0]) begin
            n_fail++;
            $display("FAIL bp_code: got %b want %b", code[0], e[2:0]);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || code[0] !== 3'b110) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b ready=%b code=%b want 0 1 110", ov[0], ir[0], code[0]);
      end
   endtask

   task automatic test_hold_lengths;
      logic [3:0] e;
      int edges;
      bit ok;
      // HOLD_CYCLES = 0
      ordy[1] = 1'b1;
      issue(1, 4'b0100, ok);
      e = ref_encode(4'b0100);
      exp_q.push_back(e[2:0]);
      wait_valid(1, edges, ok);
      n_cmp++;
      if (!ok || edges != 1) begin
         n_fail++;
         $display("FAIL hold0_latency: ok=%0d edges=%0d want 1", ok, edges);
      end
      if (exp_q.size() > 0) begin
         e[2:0] = exp_q.pop_front();
         n_cmp++;
         if (code[1] !== e[2:0]) begin
            n_fail++;
            $display("FAIL hold0_code: got %b want %b", code[1], e[2:0]);
         end
      end
      // HOLD_CYCLES = 4
      ordy[2] = 1'b1;
      issue(2, 4'b0001, ok);
      e = ref_encode(4'b0001);
      exp_q.push_back(e[2:0]);
      wait_valid(2, edges, ok);
      n_cmp++;
      if (!ok || edges != 5) begin
         n_fail++;
         $display("FAIL hold4_latency: ok=%0d edges=%0d want 5", ok, edges);
      end
      if (exp_q.size() > 0) begin
         e[2:0] = exp_q.pop_front();
         n_cmp++;
         if (code[2] !== e[2:0]) begin
            n_fail++;
            $display("FAIL hold4_code: got %b want %b", code[2], e[2:0]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_saturation;
      logic [1:0] exp_cnt;
      bit ok;
      exp_cnt = 2'd0;
      for (int i = 0; i < 5; i++) begin
         issue(1, 4'b1011, ok);
         if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
         @(negedge clk);
         n_cmp++;
         if (!ok || cnt_h0 !== exp_cnt || ill[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_cnt step %0d: ok=%0d cnt=%0d ill=%b want %0d 1",
                     i, ok, cnt_h0, ill[1], exp_cnt);
         end
      end
   endtask

   task automatic test_midop_reset;
      int seen;
      bit ok;
      issue(2, 4'b1101, ok);
      #3 resetn = 1'b0;
      #1;
      n_cmp++;
      if (!ok || ir[2] !== 1'b1 || ov[2] !== 1'b0 || code[2] !== 3'b000 || cnt_h0 !== 2'd0) begin
         n_fail++;
         $display("FAIL midop_reset: ok=%0d ready=%b valid=%b code=%b cnt0=%0d want 1 0 000 0",
                  ok, ir[2], ov[2], code[2], cnt_h0);
      end
      @(negedge clk);
      resetn = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (ov[2] !== 1'b0 || ir[2] !== 1'b1) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL midop_dropped: %0d cycles with valid/ready wrong after reset", seen);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_left: %0d entries outstanding want 0", exp_q.size());
      end
   endtask

   initial begin
      dec_tbl = '{4'b0010, 4'b0000, 4'b1101, 4'b1001, 4'b0100, 4'b0001, 4'b0111, 4'b1010};
      n_cmp  = 0;
      n_fail = 0;
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         iv[k]   = 1'b0;
         opv[k]  = 4'b0000;
         ordy[k] = 1'b0;
      end
      test_reset;
      test_encoding_sweep;
      test_illegal;
      test_backpressure;
      test_hold_lengths;
      test_saturation;
      test_midop_reset;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
